// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS control unit: Moore FSM sequencing fetch/decode/execute/writeback.
// Optional MIPS_CTRL_BNE_EN adds bne (op 000101) through the beq execute state.
module mips_multicycle_ctrl #(
    parameter int WAIT_MEM = 1,
    parameter int STATE_W  = 4
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [5:0]         op,
    input  logic [5:0]         funct,
    input  logic               zero,
    input  logic               mem_ready,
    output logic               pcen,
    output logic               irwrite,
    output logic               memwrite,
    output logic               regwrite,
    output logic               iord,
    output logic               memtoreg,
    output logic               regdst,
    output logic               alusrca,
    output logic [1:0]         alusrcb,
    output logic [1:0]         pcsrc,
    output logic [2:0]         alucontrol,
    output logic               illegal,
    output logic [STATE_W-1:0] state
);

    typedef enum logic [STATE_W-1:0] {
        FETCH   = STATE_W'(0),
        DECODE  = STATE_W'(1),
        MEMADR  = STATE_W'(2),
        MEMRD   = STATE_W'(3),
        MEMWB   = STATE_W'(4),
        MEMWR   = STATE_W'(5),
        RTYPEEX = STATE_W'(6),
        RTYPEWB = STATE_W'(7),
        BEQEX   = STATE_W'(8),
        ADDIEX  = STATE_W'(9),
        ADDIWB  = STATE_W'(10),
        JEX     = STATE_W'(11)
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    state_t state_q;
    state_t state_d;

    logic mem_ok;
    logic branch_cond;
    logic pcwrite;
    logic branch;
    logic irwrite_raw;
    logic memwrite_raw;
    logic regwrite_raw;
    logic illegal_raw;
    logic [3:0] funct_dec;

    // Returns {valid, alucontrol} for an R-type funct field.
    function automatic logic [3:0] decode_funct(input logic [5:0] f);
        case (f)
            6'b100000: decode_funct = {1'b1, 3'b010};
            6'b100010: decode_funct = {1'b1, 3'b110};
            6'b100100: decode_funct = {1'b1, 3'b000};
            6'b100101: decode_funct = {1'b1, 3'b001};
            6'b101010: decode_funct = {1'b1, 3'b111};
            default:   decode_funct = {1'b0, 3'b010};
        endcase
    endfunction

    assign mem_ok    = (WAIT_MEM != 0) ? mem_ready : 1'b1;
    assign funct_dec = decode_funct(funct);

`ifdef MIPS_CTRL_BNE_EN
    assign branch_cond = op[0] ? ~zero : zero;
`else
    assign branch_cond = zero;
`endif

    always_comb begin
        state_d      = FETCH;
        pcwrite      = 1'b0;
        branch       = 1'b0;
        irwrite_raw  = 1'b0;
        memwrite_raw = 1'b0;
        regwrite_raw = 1'b0;
        illegal_raw  = 1'b0;
        iord         = 1'b0;
        memtoreg     = 1'b0;
        regdst       = 1'b0;
        alusrca      = 1'b0;
        alusrcb      = 2'b00;
        pcsrc        = 2'b00;
        alucontrol   = 3'b010;
        case (state_q)
            FETCH: begin
                alusrcb     = 2'b01;
                irwrite_raw = mem_ok;
                pcwrite     = mem_ok;
                state_d     = mem_ok ? DECODE : FETCH;
            end
            DECODE: begin
                alusrcb = 2'b11;
                case (op)
                    OP_LW, OP_SW: state_d = MEMADR;
                    OP_RTYPE:     state_d = RTYPEEX;
                    OP_BEQ:       state_d = BEQEX;
`ifdef MIPS_CTRL_BNE_EN
                    OP_BNE:       state_d = BEQEX;
`endif
                    OP_ADDI:      state_d = ADDIEX;
                    OP_J:         state_d = JEX;
                    default: begin
                        state_d     = FETCH;
                        illegal_raw = 1'b1;
                    end
                endcase
            end
            MEMADR: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
                // op[3] separates sw (101011) from lw (100011)
                state_d = op[3] ? MEMWR : MEMRD;
            end
            MEMRD: begin
                iord    = 1'b1;
                state_d = mem_ok ? MEMWB : MEMRD;
            end
            MEMWB: begin
                memtoreg     = 1'b1;
                regwrite_raw = 1'b1;
            end
            MEMWR: begin
                iord         = 1'b1;
                memwrite_raw = 1'b1;
                state_d      = mem_ok ? FETCH : MEMWR;
            end
            RTYPEEX: begin
                alusrca     = 1'b1;
                alucontrol  = funct_dec[2:0];
                illegal_raw = ~funct_dec[3];
                state_d     = funct_dec[3] ? RTYPEWB : FETCH;
            end
            RTYPEWB: begin
                regdst       = 1'b1;
                regwrite_raw = 1'b1;
            end
            BEQEX: begin
                alusrca    = 1'b1;
                alucontrol = 3'b110;
                pcsrc      = 2'b01;
                branch     = 1'b1;
            end
            ADDIEX: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
                state_d = ADDIWB;
            end
            ADDIWB: regwrite_raw = 1'b1;
            JEX: begin
                pcsrc   = 2'b10;
                pcwrite = 1'b1;
            end
            default: state_d = FETCH;
        endcase
    end

    // Write enables are held off for the whole reset cycle so an aborted access never commits.
    assign pcen     = reset_n & (pcwrite | (branch & branch_cond));
    assign irwrite  = reset_n & irwrite_raw;
    assign memwrite = reset_n & memwrite_raw;
    assign regwrite = reset_n & regwrite_raw;
    assign illegal  = reset_n & illegal_raw;
    assign state    = state_q;

    always_ff @(posedge clk) begin
        if (!reset_n) state_q <= FETCH;
        else          state_q <= state_d;
    end

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Self-checking bench for mips_multicycle_ctrl: directed scenarios plus a randomized
// instruction stream checked against a per-instruction expected-cycle table.
module tb_mips_multicycle_ctrl;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic       mem_ready;
    logic       pcen, irwrite, memwrite, regwrite, iord, memtoreg, regdst, alusrca, illegal;
    logic [1:0] alusrcb, pcsrc;
    logic [2:0] alucontrol;
    logic [3:0] state;

    int errors = 0;
    int checks = 0;

    mips_multicycle_ctrl #(.WAIT_MEM(1), .STATE_W(4)) dut (
        .clk(clk), .reset_n(reset_n), .op(op), .funct(funct), .zero(zero),
        .mem_ready(mem_ready), .pcen(pcen), .irwrite(irwrite), .memwrite(memwrite),
        .regwrite(regwrite), .iord(iord), .memtoreg(memtoreg), .regdst(regdst),
        .alusrca(alusrca), .alusrcb(alusrcb), .pcsrc(pcsrc), .alucontrol(alucontrol),
        .illegal(illegal), .state(state)
    );

    always #5 clk = ~clk;

    // One expected cycle: state, control values and how pcen/irwrite follow the inputs
    // (kind 0 = 0, 1 = 1, 2 = mem_ready, 3 = zero, 4 = ~zero).
    typedef struct {
        int         st;
        logic [1:0] srcb;
        logic [1:0] psrc;
        logic [2:0] alu;
        logic       a, io, m2r, rd, rw, mw, ill;
        int         pk, ik;
        bit         waits;
    } exp_t;

    exp_t plan_q[$];

    function automatic exp_t blank(input int st);
        exp_t e;
        e.st = st; e.srcb = 2'b00; e.psrc = 2'b00; e.alu = 3'b010;
        e.a = 0; e.io = 0; e.m2r = 0; e.rd = 0; e.rw = 0; e.mw = 0; e.ill = 0;
        e.pk = 0; e.ik = 0; e.waits = 0;
        return e;
    endfunction

    function automatic void build(input logic [5:0] o, input logic [5:0] f);
        exp_t e, d;
        e = blank(0); e.srcb = 2'b01; e.pk = 2; e.ik = 2; e.waits = 1;
        plan_q.push_back(e);
        d = blank(1); d.srcb = 2'b11;
        if (o == 6'b100011 || o == 6'b101011) begin
            plan_q.push_back(d);
            e = blank(2); e.a = 1; e.srcb = 2'b10; plan_q.push_back(e);
            if (o == 6'b100011) begin
                e = blank(3); e.io = 1; e.waits = 1; plan_q.push_back(e);
                e = blank(4); e.m2r = 1; e.rw = 1; plan_q.push_back(e);
            end else begin
                e = blank(5); e.io = 1; e.mw = 1; e.waits = 1; plan_q.push_back(e);
            end
        end else if (o == 6'b000000) begin
            plan_q.push_back(d);
            e = blank(6); e.a = 1;
            case (f)
                6'b100000: e.alu = 3'b010;
                6'b100010: e.alu = 3'b110;
                6'b100100: e.alu = 3'b000;
                6'b100101: e.alu = 3'b001;
                6'b101010: e.alu = 3'b111;
                default:   e.ill = 1;
            endcase
            plan_q.push_back(e);
            if (!e.ill) begin
                e = blank(7); e.rd = 1; e.rw = 1; plan_q.push_back(e);
            end
`ifdef MIPS_CTRL_BNE_EN
        end else if (o == 6'b000100 || o == 6'b000101) begin
`else
        end else if (o == 6'b000100) begin
`endif
            plan_q.push_back(d);
            e = blank(8); e.a = 1; e.alu = 3'b110; e.psrc = 2'b01; e.pk = o[0] ? 4 : 3;
            plan_q.push_back(e);
        end else if (o == 6'b001000) begin
            plan_q.push_back(d);
            e = blank(9); e.a = 1; e.srcb = 2'b10; plan_q.push_back(e);
            e = blank(10); e.rw = 1; plan_q.push_back(e);
        end else if (o == 6'b000010) begin
            plan_q.push_back(d);
            e = blank(11); e.psrc = 2'b10; e.pk = 1; plan_q.push_back(e);
        end else begin
            d.ill = 1;
            plan_q.push_back(d);
        end
    endfunction

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; mem_ready = 1'b1; zero = 1'b0; op = 6'b0; funct = 6'b100000;
        step();
        checks++;
        if ({pcen, irwrite, regwrite, memwrite, illegal} !== 5'b0)
            $display("FAIL reset_enables got=%b exp=00000", {pcen, irwrite, regwrite, memwrite, illegal});
        checks++;
        if (state !== 4'd0) $display("FAIL reset_state got=%0d exp=0", state);
        if (state !== 4'd0) errors++;
        if ({pcen, irwrite, regwrite, memwrite, illegal} !== 5'b0) errors++;
        step();
        reset_n = 1'b1;
        #1;
        checks++;
        if (state !== 4'd0) begin errors++; $display("FAIL release_state got=%0d exp=0", state); end
        checks++;
        if ({irwrite, pcen} !== 2'b11) begin
            errors++; $display("FAIL release_fetch got=%b exp=11", {irwrite, pcen});
        end
    endtask

    task automatic test_lw();
        int exp_st[5] = '{0, 1, 2, 3, 4};
        op = 6'b100011; mem_ready = 1'b1; zero = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++;
            if (state !== exp_st[i]) begin
                errors++; $display("FAIL lw_state got=%0d exp=%0d", state, exp_st[i]);
            end
            if (i == 2) begin
                checks++;
                if ({alusrcb, alucontrol} !== 5'b10_010) begin
                    errors++; $display("FAIL lw_memadr got=%b exp=10010", {alusrcb, alucontrol});
                end
            end
            if (i == 4) begin
                checks++;
                if ({regwrite, memtoreg} !== 2'b11) begin
                    errors++; $display("FAIL lw_memwb got=%b exp=11", {regwrite, memtoreg});
                end
            end
            step();
        end
        #1;
        checks++;
        if (state !== 4'd0) begin errors++; $display("FAIL lw_end got=%0d exp=0", state); end
    endtask

    task automatic test_rtype();
        int exp_st[4] = '{0, 1, 6, 7};
        op = 6'b000000; funct = 6'b101010; mem_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++;
            if (state !== exp_st[i]) begin
                errors++; $display("FAIL slt_state got=%0d exp=%0d", state, exp_st[i]);
            end
            if (i == 2) begin
                checks++;
                if (alucontrol !== 3'b111) begin
                    errors++; $display("FAIL slt_alu got=%b exp=111", alucontrol);
                end
            end
            if (i == 3) begin
                checks++;
                if ({regdst, regwrite} !== 2'b11) begin
                    errors++; $display("FAIL slt_wb got=%b exp=11", {regdst, regwrite});
                end
            end
            step();
        end
        funct = 6'b000000;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (state !== exp_st[i]) begin
                errors++; $display("FAIL badfunct_state got=%0d exp=%0d", state, exp_st[i]);
            end
            if (i == 2) begin
                checks++;
                if ({illegal, regwrite} !== 2'b10) begin
                    errors++; $display("FAIL badfunct_ill got=%b exp=10", {illegal, regwrite});
                end
            end
            step();
        end
        #1;
        checks++;
        if ({state, regwrite} !== 5'b0000_0) begin
            errors++; $display("FAIL badfunct_end got=%b exp=00000", {state, regwrite});
        end
    endtask

    task automatic test_beq();
        int exp_st[3] = '{0, 1, 8};
        for (int z = 1; z >= 0; z--) begin
            op = 6'b000100; zero = z[0]; mem_ready = 1'b1;
            for (int i = 0; i < 3; i++) begin
                #1;
                checks++;
                if (state !== exp_st[i]) begin
                    errors++; $display("FAIL beq_state got=%0d exp=%0d", state, exp_st[i]);
                end
                if (i == 2) begin
                    checks++;
                    if ({pcen, pcsrc, alucontrol} !== {z[0], 2'b01, 3'b110}) begin
                        errors++;
                        $display("FAIL beq_ex zero=%0d got=%b exp=%b", z, {pcen, pcsrc, alucontrol}, {z[0], 5'b01110});
                    end
                end
                step();
            end
            #1;
            checks++;
            if (state !== 4'd0) begin errors++; $display("FAIL beq_end got=%0d exp=0", state); end
        end
    endtask

    task automatic test_sw_stall();
        op = 6'b101011; mem_ready = 1'b1;
        for (int i = 0; i < 3; i++) step();
        mem_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) mem_ready = 1'b1;
            #1;
            checks++;
            if ({state, memwrite} !== 5'b0101_1) begin
                errors++; $display("FAIL sw_stall cyc=%0d got=%b exp=01011", i, {state, memwrite});
            end
            step();
        end
        #1;
        checks++;
        if (state !== 4'd0) begin errors++; $display("FAIL sw_end got=%0d exp=0", state); end
        for (int i = 0; i < 3; i++) step();
        mem_ready = 1'b0;
        step();
        reset_n = 1'b0;
        #1;
        checks++;
        if ({state, memwrite} !== 5'b0101_0) begin
            errors++; $display("FAIL sw_reset_we got=%b exp=01010", {state, memwrite});
        end
        step();
        reset_n = 1'b1; mem_ready = 1'b1;
        #1;
        checks++;
        if (state !== 4'd0) begin errors++; $display("FAIL sw_reset_state got=%0d exp=0", state); end
    endtask

    task automatic test_bne();
        op = 6'b000101; zero = 1'b0; mem_ready = 1'b1;
        step();
        #1;
        checks++;
`ifdef MIPS_CTRL_BNE_EN
        if ({state, illegal} !== 5'b0001_0) begin
            errors++; $display("FAIL bne_decode got=%b exp=00010", {state, illegal});
        end
        step();
        #1;
        checks++;
        if ({state, pcen} !== 5'b1000_1) begin
            errors++; $display("FAIL bne_taken got=%b exp=10001", {state, pcen});
        end
`else
        if ({state, illegal} !== 5'b0001_1) begin
            errors++; $display("FAIL bne_illegal got=%b exp=00011", {state, illegal});
        end
`endif
        step();
        #1;
        checks++;
        if (state !== 4'd0) begin errors++; $display("FAIL bne_end got=%0d exp=0", state); end
    endtask

    task automatic test_random();
        logic [5:0] ops[8]    = '{6'b100011, 6'b101011, 6'b000000, 6'b000100,
                                  6'b000101, 6'b001000, 6'b000010, 6'b111111};
        logic [5:0] functs[6] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101,
                                  6'b101010, 6'b000111};
        for (int n = 0; n < 80; n++) begin
            int stalls = 0;
            op    = ops[$urandom_range(0, 7)];
            funct = functs[$urandom_range(0, 5)];
            if ($urandom_range(0, 7) == 0) op = 6'($urandom);
            build(op, funct);
            while (plan_q.size() != 0) begin
                exp_t e;
                logic [19:0] got, want;
                logic pe, ie;
                e = plan_q[0];
                zero = 1'($urandom);
                if (e.waits) mem_ready = (stalls >= 5) ? 1'b1 : ($urandom_range(0, 3) != 0);
                else         mem_ready = 1'($urandom);
                #1;
                pe = (e.pk == 1) ? 1'b1 : (e.pk == 2) ? mem_ready : (e.pk == 3) ? zero :
                     (e.pk == 4) ? ~zero : 1'b0;
                ie = (e.ik == 2) ? mem_ready : 1'b0;
                want = {4'(e.st), pe, ie, e.mw, e.rw, e.io, e.m2r, e.rd, e.a,
                        e.srcb, e.psrc, e.alu, e.ill};
                got  = {state, pcen, irwrite, memwrite, regwrite, iord, memtoreg, regdst,
                        alusrca, alusrcb, pcsrc, alucontrol, illegal};
                checks++;
                if (got !== want) begin
                    errors++;
                    $display("FAIL random op=%b funct=%b got=%h exp=%h", op, funct, got, want);
                end
                if (e.waits && !mem_ready) stalls++;
                else begin
                    void'(plan_q.pop_front());
                    stalls = 0;
                end
                step();
            end
        end
    endtask

    initial begin
        test_reset();
        test_lw();
        test_rtype();
        test_beq();
        test_sw_stall();
        test_bne();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
